tt_um_uwasic_onboarding_karan_kapoor: RTL and testbench
=======================================================

TT_UM_UWASIC_ONBOARDING_KARAN_KAPOOR -- requirements
Module: tt_um_uwasic_onboarding_karan_kapoor

Interface
REQ-001 Parameter CLK_DIV, default 3333, PWM period in clk cycles (about 3 kHz at 10 MHz clk).
REQ-002 Parameter MAX_ADDR, default 4, highest writable register address.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-high (asserted when rst_n=1, sampled on clk rising edge).
REQ-005 ena  in  1  tile-select; ignored by logic.
REQ-006 ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low chip select); [7:3] unused.
REQ-007 uio_in  in  8  unused.
REQ-008 uo_out  out  8  output bits out[7:0].
REQ-009 uio_out  out  8  output bits out[15:8].
REQ-010 uio_oe  out  8  constant 8'hFF (all bidirectional pins driven as outputs).

Function
REQ-011 SCLK, COPI, nCS each pass through a 2-flop synchronizer to clk; edges are detected on the synchronized values.
REQ-012 Transaction starts on synchronized nCS falling edge; bit counter and shift register clear at that point.
REQ-013 While nCS is low, on each synchronized SCLK rising edge, COPI shifts into a 16-bit shift register MSB-first and the bit counter increments, saturating at 17.
REQ-014 Frame format: bit15 = R/W (1=write), bits14:8 = 7-bit address, bits7:0 = data.
REQ-015 Commit occurs on synchronized nCS rising edge, only when exactly 16 bits were received, R/W=1 and address <= MAX_ADDR; otherwise the frame is discarded with no register change.
REQ-016 Register map, all 8-bit: 0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 en_pwm[7:0]; 0x03 en_pwm[15:8]; 0x04 duty.
REQ-017 Committed data is visible in registers on the clk edge following the nCS rising edge (latency of at most 4 clk from the raw nCS edge, including synchronizers).
REQ-018 Read frames (R/W=0) have no effect; there is no MISO output.
REQ-019 PWM counter runs 0..CLK_DIV-1, then wraps to 0, incrementing every clk.
REQ-020 pwm = 1 when duty==8'hFF; otherwise pwm = (counter < (duty*CLK_DIV)>>8), using at least 20-bit unsigned product; duty=0 gives constant 0.
REQ-021 For each i in 0..15: out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
REQ-022 Outputs are combinational from registers and pwm, without an extra output pipeline stage.
REQ-023 If a frame is in progress when nCS rises with fewer or more than 16 SCLK edges, the frame is dropped, and the next nCS falling edge starts a fresh frame.
REQ-024 SCLK edges while nCS is high are ignored.

Reset
REQ-025 On reset, all five registers = 0x00, PWM counter = 0, shift register and bit counter = 0, and synchronizer flops load idle values (SCLK=0, COPI=0, nCS=1).
REQ-026 During and after reset, uo_out=0x00 and uio_out=0x00; uio_oe=0xFF at all times.
REQ-027 Reset asserted mid-transaction aborts the frame, so no commit occurs on the subsequent nCS rise unless a new full frame follows.

Verification
REQ-028 Apply reset, then write 0x00<-0xF0 -> uo_out=0xF0 within 4 clk of nCS rise.
REQ-029 Write 0x01<-0xCC -> uio_out=0xCC, with uo_out unchanged.
REQ-030 Write en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3333 clk ±1 and high time 1666 clk ±1 (50%).
REQ-031 duty=0x00 -> uo_out[0] constant 0; duty=0xFF -> constant 1, for at least 2 periods.
REQ-032 Write to address 0x30, a read frame (R/W=0) to 0x00, and a 15-bit frame -> all registers unchanged.
REQ-033 Assert reset mid-frame after 8 bits, then release with nCS high -> outputs 0x00, and a subsequent valid frame commits normally.

Source files
------------

// File: rtl/tt_um_uwasic_onboarding_karan_kapoor.sv
// SPI-write register file driving 16 outputs, each optionally gated by a shared PWM.
// Frames are 16 bits MSB-first: {write, addr[6:0], data[7:0]}, committed on the nCS rising edge.
module tt_um_uwasic_onboarding_karan_kapoor #(
    parameter int CLK_DIV  = 3333,
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int         CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0] MAX_A  = 7'(MAX_ADDR);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic       r_copi_s1, r_copi_s2;
    logic       r_ncs_s1,  r_ncs_s2,  r_ncs_d;
    logic [15:0] r_shift;
    logic [4:0]  r_bits;
    logic [7:0]  r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
    logic [CW-1:0] r_pwm_cnt;

    logic        w_sclk_rise, w_ncs_fall, w_ncs_rise, w_commit;
    logic [31:0] w_product, w_thresh;
    logic        w_pwm;
    logic [15:0] w_en_out, w_en_pwm, w_out;
    logic        w_unused_ok;

    assign w_unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_ncs_fall  = ~r_ncs_s2 & r_ncs_d;
    assign w_ncs_rise  = r_ncs_s2 & ~r_ncs_d;
    assign w_commit    = w_ncs_rise && (r_bits == 5'd16) && r_shift[15] && (r_shift[14:8] <= MAX_A);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_copi_s1 <= 1'b0;
            r_copi_s2 <= 1'b0;
            r_ncs_s1  <= 1'b1;
            r_ncs_s2  <= 1'b1;
            r_ncs_d   <= 1'b1;
        end else begin
            r_sclk_s1 <= ui_in[0];
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_copi_s1 <= ui_in[1];
            r_copi_s2 <= r_copi_s1;
            r_ncs_s1  <= ui_in[2];
            r_ncs_s2  <= r_ncs_s1;
            r_ncs_d   <= r_ncs_s2;
        end
    end

    // Counter saturates at 17 so any overlong frame stays distinguishable from a 16-bit one.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_shift <= 16'h0000;
            r_bits  <= 5'd0;
        end else if (w_ncs_fall) begin
            r_shift <= 16'h0000;
            r_bits  <= 5'd0;
        end else if (!r_ncs_s2 && w_sclk_rise) begin
            r_shift <= {r_shift[14:0], r_copi_s2};
            if (r_bits != 5'd17)
                r_bits <= r_bits + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_en_out_lo <= 8'h00;
            r_en_out_hi <= 8'h00;
            r_en_pwm_lo <= 8'h00;
            r_en_pwm_hi <= 8'h00;
            r_duty      <= 8'h00;
        end else if (w_commit) begin
            case (r_shift[14:8])
                7'd0:    r_en_out_lo <= r_shift[7:0];
                7'd1:    r_en_out_hi <= r_shift[7:0];
                7'd2:    r_en_pwm_lo <= r_shift[7:0];
                7'd3:    r_en_pwm_hi <= r_shift[7:0];
                7'd4:    r_duty      <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            r_pwm_cnt <= '0;
        else if (r_pwm_cnt == CNT_LAST)
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + CW'(1);
    end

    assign w_product = 32'(r_duty) * 32'(CLK_DIV);
    assign w_thresh  = w_product >> 8;
    assign w_pwm     = (r_duty == 8'hFF) ? 1'b1 : (32'(r_pwm_cnt) < w_thresh);

    assign w_en_out = {r_en_out_hi, r_en_out_lo};
    assign w_en_pwm = {r_en_pwm_hi, r_en_pwm_lo};
    assign w_out    = w_en_out & (~w_en_pwm | {16{w_pwm}});

    assign uo_out  = w_out[7:0];
    assign uio_out = w_out[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_karan_kapoor.sv
// Self-checking bench: SPI frame vectors through a scoreboard queue, plus PWM and reset sequences.
module tb_tt_um_uwasic_onboarding_karan_kapoor;

    localparam int CLK_DIV = 3333;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    logic [15:0] sb_q[$];
    vec_t vecs[13];

    assign ui_in  = {5'b0, ncs, copi, sclk};
    assign uio_in = 8'h00;

    always #5 clk = ~clk;

    tt_um_uwasic_onboarding_karan_kapoor #(.CLK_DIV(CLK_DIV), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clock_bits(input logic [15:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            copi = (i < 16) ? w[15 - i] : 1'b0;
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int nbits);
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        clock_bits(w, 0, nbits);
        repeat (3) @(negedge clk);
        ncs = 1'b1;
    endtask

    task automatic do_frame(input string name, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits,
                            input logic [7:0] exp_uo, input logic [7:0] exp_uio);
        logic [15:0] got, exp;
        sb_q.push_back({exp_uio, exp_uo});
        send_frame({rw, addr, data}, nbits);
        repeat (4) @(negedge clk);
        exp = sb_q.pop_front();
        got = {uio_out, uo_out};
        check(name, got, exp);
        repeat (3) @(negedge clk);
    endtask

    task automatic count_const(input string name, input logic [7:0] want, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (uo_out !== want) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int high, low, k;
        bit seen;

        vecs[0]  = '{"wr0_f0",      1'b1, 7'h00, 8'hF0, 16, 8'hF0, 8'h00};
        vecs[1]  = '{"wr1_cc",      1'b1, 7'h01, 8'hCC, 16, 8'hF0, 8'hCC};
        vecs[2]  = '{"wr_addr30",   1'b1, 7'h30, 8'h55, 16, 8'hF0, 8'hCC};
        vecs[3]  = '{"read_frame",  1'b0, 7'h00, 8'h0F, 16, 8'hF0, 8'hCC};
        vecs[4]  = '{"bits15",      1'b1, 7'h00, 8'h0F, 15, 8'hF0, 8'hCC};
        vecs[5]  = '{"bits17",      1'b1, 7'h00, 8'h0F, 17, 8'hF0, 8'hCC};
        vecs[6]  = '{"wr_addr5",    1'b1, 7'h05, 8'hFF, 16, 8'hF0, 8'hCC};
        vecs[7]  = '{"pwmlo_duty0", 1'b1, 7'h02, 8'hF0, 16, 8'h00, 8'hCC};
        vecs[8]  = '{"duty_ff",     1'b1, 7'h04, 8'hFF, 16, 8'hF0, 8'hCC};
        vecs[9]  = '{"pwmhi_0c",    1'b1, 7'h03, 8'h0C, 16, 8'hF0, 8'hCC};
        vecs[10] = '{"duty_00",     1'b1, 7'h04, 8'h00, 16, 8'h00, 8'hC0};
        vecs[11] = '{"wr0_5a",      1'b1, 7'h00, 8'h5A, 16, 8'h0A, 8'hC0};
        vecs[12] = '{"pwmlo_00",    1'b1, 7'h02, 8'h00, 16, 8'h5A, 8'hC0};

        repeat (4) @(negedge clk);
        check("in_reset_out", {uio_out, uo_out}, 16'h0000);
        check("in_reset_oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_out", {uio_out, uo_out}, 16'h0000);

        foreach (vecs[i])
            do_frame(vecs[i].name, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].nbits,
                     vecs[i].exp_uo, vecs[i].exp_uio);

        // 50% PWM on bit 0 only
        do_frame("pwm_en_out", 1'b1, 7'h00, 8'h01, 16, 8'h01, 8'hC0);
        do_frame("pwm_en_pwm", 1'b1, 7'h02, 8'h01, 16, 8'h00, 8'hC0);
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        clock_bits({1'b1, 7'h04, 8'h80}, 0, 16);
        repeat (3) @(negedge clk);
        ncs = 1'b1;
        repeat (6) @(negedge clk);

        seen = 0;
        k = 0;
        while (!seen && k < 8000) begin
            logic prev;
            prev = uo_out[0];
            @(negedge clk);
            k++;
            if (!prev && uo_out[0]) seen = 1;
        end
        check("pwm_rise_found", seen, 1'b1);
        high = 0;
        while (uo_out[0] === 1'b1 && high < 8000) begin @(negedge clk); high++; end
        low = 0;
        while (uo_out[0] === 1'b0 && low < 8000) begin @(negedge clk); low++; end
        check("pwm_high_1666", (high >= 1665 && high <= 1667), 1'b1);
        check("pwm_period_3333", ((high + low) >= 3332 && (high + low) <= 3334), 1'b1);
        if (!((high >= 1665 && high <= 1667) && ((high + low) >= 3332 && (high + low) <= 3334)))
            $display("pwm measured high=%0d period=%0d", high, high + low);

        do_frame("duty_set_00", 1'b1, 7'h04, 8'h00, 16, 8'h00, 8'hC0);
        count_const("duty00_const0", 8'h00, 2 * CLK_DIV + 10);
        do_frame("duty_set_ff", 1'b1, 7'h04, 8'hFF, 16, 8'h01, 8'hCC);
        count_const("dutyff_const1", 8'h01, 2 * CLK_DIV + 10);

        // reset after 8 bits, nCS released while reset is held
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        clock_bits({1'b1, 7'h01, 8'hAA}, 0, 8);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        ncs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("midframe_rst_out", {uio_out, uo_out}, 16'h0000);

        // reset released with nCS still low; tail of the frame must not commit
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        clock_bits({1'b1, 7'h00, 8'hFF}, 0, 8);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        clock_bits({1'b1, 7'h00, 8'hFF}, 8, 8);
        repeat (3) @(negedge clk);
        ncs = 1'b1;
        repeat (6) @(negedge clk);
        check("aborted_tail_nocommit", {uio_out, uo_out}, 16'h0000);

        do_frame("post_rst_valid", 1'b1, 7'h01, 8'h3C, 16, 8'h00, 8'h3C);
        check("oe_const", uio_oe, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
